// File: rtl/rf_multiport.sv
// rf_multiport: parametrised multi-read-port register file.
// Writes are byte-strobed. A same-cycle write can optionally be forwarded to
// the read ports, and entry 0 can optionally be hard-wired to zero. After reset,
// or when clear_req is pulsed, a sequencer scrubs the array one entry per cycle.
// Read data is forced to zero while that sweep runs.
module rf_multiport #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int NUM_READ = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH),
  localparam int NB       = WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear_req,
  output logic                      busy,
  input  logic                      write_enable,
  input  logic [AW-1:0]             write_reg,
  input  logic [WIDTH-1:0]          write_data,
  input  logic [NB-1:0]             write_strobe,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   next_idx;
  logic            wr_en;
  logic [WIDTH-1:0] mem [DEPTH];

  // State register: reset always restarts the sweep from entry 0.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
    end
  end

  // Next-state logic: advance the sweep, or start one on clear_req while idle.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    next_idx   = idx;
    unique case (state)
      ST_CLEAR: begin
        next_idx = idx + AW'(1);
        if (idx == AW'(DEPTH - 1)) begin
          next_state = ST_IDLE;
          next_idx   = '0;
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          next_state = ST_CLEAR;
          next_idx   = '0;
        end
      end
      default: begin
        next_state = ST_CLEAR;
        next_idx   = '0;
      end
    endcase
  end

  // Output logic: the busy flag, and the qualified write enable. Writes are
  // dropped while sweeping, during reset, and to entry 0 when it is hard-wired.
  always_comb begin
    busy  = (state == ST_CLEAR);
    wr_en = write_enable && !busy && !rst &&
            !((ZERO_REG != 0) && (write_reg == '0));
  end

  // Array update: the sweep zeroes entry idx; otherwise apply the strobed bytes.
  // NOTE: the array has no reset branch; the clear sweep scrubs it, so it maps onto plain RAM/flops without reset.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[idx] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (write_strobe[b]) mem[write_reg][8*b +: 8] <= write_data[8*b +: 8];
      end
    end
  end

  // Read ports: zero while busy or for hard-wired entry 0. When bypass is
  // enabled, strobed bytes of a same-cycle write are merged into the data.
  always_comb begin
    logic [WIDTH-1:0] word;
    logic [AW-1:0]    addr;
    rd_data = '0;
    word    = '0;
    addr    = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      addr = rd_addr[p*AW +: AW];
      word = mem[addr];
      if ((BYPASS != 0) && write_enable && (addr == write_reg)) begin
        for (int b = 0; b < NB; b++) begin
          if (write_strobe[b]) word[8*b +: 8] = write_data[8*b +: 8];
        end
      end
      if (busy || ((ZERO_REG != 0) && (addr == '0))) word = '0;
      rd_data[p*WIDTH +: WIDTH] = word;
    end
  end

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: directed bench for rf_multiport.
// dut uses the default configuration. dut_alt uses BYPASS=0 and ZERO_REG=0 and
// shares all inputs with dut, so the two can be compared against their own
// expected values on every step.
module tb_rf_multiport;

  logic        clk;
  logic        rst;
  logic        clear_req;
  logic        busy;
  logic        busy_alt;
  logic        write_enable;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [3:0]  write_strobe;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] rd_data_alt;

  int checks = 0;
  int errors = 0;

  rf_multiport dut (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .busy         (busy),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_strobe (write_strobe),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data)
  );

  rf_multiport #(.BYPASS(0), .ZERO_REG(0)) dut_alt (
    .clk          (clk),
    .rst          (rst),
    .clear_req    (clear_req),
    .busy         (busy_alt),
    .write_enable (write_enable),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_strobe (write_strobe),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data_alt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then step just past it so that inputs change away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    rst          = 1'b1;
    clear_req    = 1'b0;
    write_enable = 1'b0;
    write_reg    = '0;
    write_data   = '0;
    write_strobe = '0;
    rd_addr      = '0;

    // 1: reset, then a full sweep of 32 edges, then every entry reads 0
    tick();
    tick();
    set_rd(5'd31, 5'd3);
    #1;
    chk("busy_in_reset", 32'(busy), 32'd1);
    chk("rd0_in_reset", rd_data[31:0], 32'h0);
    chk("rd1_in_reset", rd_data[63:32], 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("busy_sweep_%0d", i), 32'(busy), 32'd1);
      tick();
    end
    chk("busy_after_sweep", 32'(busy), 32'd0);
    chk("busy_alt_after_sweep", 32'(busy_alt), 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      #1;
      chk($sformatf("reset_rd0_r%0d", i), rd_data[31:0], 32'h0);
      chk($sformatf("reset_rd1_r%0d", 31 - i), rd_data[63:32], 32'h0);
      chk($sformatf("reset_alt_r%0d", i), rd_data_alt[31:0], 32'h0);
    end

    // 2: byte strobes, including a partial-strobe bypass merge and a zero-strobe no-op
    write_enable = 1'b1;
    write_reg    = 5'd5;
    write_data   = 32'hDEADBEEF;
    write_strobe = 4'hF;
    set_rd(5'd5, 5'd5);
    tick();
    write_data   = 32'h11223344;
    write_strobe = 4'h5;
    #1;
    chk("strb_bypass_merge", rd_data[31:0], 32'hDE22BE44);
    chk("strb_alt_old", rd_data_alt[31:0], 32'hDEADBEEF);
    tick();
    write_enable = 1'b0;
    #1;
    chk("strb_r5_p0", rd_data[31:0], 32'hDE22BE44);
    chk("strb_r5_p1", rd_data[63:32], 32'hDE22BE44);
    chk("strb_alt_r5", rd_data_alt[31:0], 32'hDE22BE44);
    write_enable = 1'b1;
    write_data   = 32'hFFFFFFFF;
    write_strobe = 4'h0;
    #1;
    chk("strb0_bypass", rd_data[31:0], 32'hDE22BE44);
    tick();
    write_enable = 1'b0;
    #1;
    chk("strb0_r5", rd_data[31:0], 32'hDE22BE44);
    chk("strb0_alt_r5", rd_data_alt[31:0], 32'hDE22BE44);

    // 3: a same-cycle write is forwarded with bypass, and seen one cycle later without it
    write_enable = 1'b1;
    write_reg    = 5'd7;
    write_data   = 32'hCAFEF00D;
    write_strobe = 4'hF;
    set_rd(5'd7, 5'd7);
    #1;
    chk("bypass_p0", rd_data[31:0], 32'hCAFEF00D);
    chk("bypass_p1", rd_data[63:32], 32'hCAFEF00D);
    chk("nobypass_old", rd_data_alt[31:0], 32'h0);
    tick();
    write_enable = 1'b0;
    #1;
    chk("bypass_after", rd_data[31:0], 32'hCAFEF00D);
    chk("nobypass_new", rd_data_alt[31:0], 32'hCAFEF00D);

    // 4: entry 0 is hard-wired to zero in dut and is an ordinary entry in dut_alt
    write_enable = 1'b1;
    write_reg    = 5'd0;
    write_data   = 32'hFFFFFFFF;
    write_strobe = 4'hF;
    set_rd(5'd0, 5'd0);
    #1;
    chk("zero_bypass_p0", rd_data[31:0], 32'h0);
    chk("zero_bypass_p1", rd_data[63:32], 32'h0);
    chk("zero_alt_same_cycle", rd_data_alt[31:0], 32'h0);
    tick();
    write_enable = 1'b0;
    #1;
    chk("zero_p0", rd_data[31:0], 32'h0);
    chk("zero_p1", rd_data[63:32], 32'h0);
    chk("zero_alt_p0", rd_data_alt[31:0], 32'hFFFFFFFF);
    chk("zero_alt_p1", rd_data_alt[63:32], 32'hFFFFFFFF);

    // 5: fill, then clear with a write in the same cycle; writes and clear_req during busy are dropped
    for (int i = 1; i < 32; i++) begin
      write_enable = 1'b1;
      write_reg    = 5'(i);
      write_data   = 32'(i);
      write_strobe = 4'hF;
      tick();
    end
    write_enable = 1'b0;
    set_rd(5'd17, 5'd31);
    #1;
    chk("fill_r17", rd_data[31:0], 32'd17);
    chk("fill_r31", rd_data[63:32], 32'd31);
    write_enable = 1'b1;
    write_reg    = 5'd3;
    write_data   = 32'h000000AA;
    write_strobe = 4'hF;
    clear_req    = 1'b1;
    set_rd(5'd3, 5'd3);
    #1;
    chk("clear_cycle_bypass_r3", rd_data[31:0], 32'h000000AA);
    chk("clear_cycle_busy", 32'(busy), 32'd0);
    tick();
    for (int i = 0; i < 32; i++) begin
      clear_req    = 1'b1;
      write_enable = 1'b1;
      write_reg    = 5'd1;
      write_data   = 32'h00005555;
      write_strobe = 4'hF;
      set_rd(5'd1, 5'd3);
      #1;
      chk($sformatf("clear_busy_%0d", i), 32'(busy), 32'd1);
      chk($sformatf("clear_rd_zero_%0d", i), rd_data[31:0], 32'h0);
      tick();
    end
    clear_req    = 1'b0;
    write_enable = 1'b0;
    #1;
    chk("clear_done", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      #1;
      chk($sformatf("clear_rd0_r%0d", i), rd_data[31:0], 32'h0);
      chk($sformatf("clear_rd1_r%0d", 31 - i), rd_data[63:32], 32'h0);
      chk($sformatf("clear_alt_r%0d", i), rd_data_alt[31:0], 32'h0);
    end

    // 6: reset at sweep index 10 restarts the sweep; r31 reads 0 throughout and after
    write_enable = 1'b1;
    write_reg    = 5'd31;
    write_data   = 32'h31313131;
    write_strobe = 4'hF;
    tick();
    write_enable = 1'b0;
    set_rd(5'd31, 5'd31);
    #1;
    chk("pre_clear_r31", rd_data[31:0], 32'h31313131);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("mid_r31_%0d", i), rd_data[31:0], 32'h0);
      tick();
    end
    chk("mid_busy_idx10", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk($sformatf("rst_mid_busy_%0d", i), 32'(busy), 32'd1);
      chk($sformatf("rst_mid_p0_%0d", i), rd_data[31:0], 32'h0);
      chk($sformatf("rst_mid_p1_%0d", i), rd_data[63:32], 32'h0);
      tick();
    end
    chk("rst_mid_done", 32'(busy), 32'd0);
    chk("rst_mid_r31_p0", rd_data[31:0], 32'h0);
    chk("rst_mid_r31_p1", rd_data[63:32], 32'h0);
    chk("rst_mid_alt_r31", rd_data_alt[31:0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
